// File: rtl/cmd_frame_rx_if.sv
// cmd_frame_rx_if
//   Output bundle of the command frame receiver.
//   Handshake: command_rx_ready is a one-clk valid strobe with no ready/backpressure path;
//   command_rx/data_field_rx are valid in that clk and hold until the next good frame, so
//   the consumer must capture on the strobe. rx_err, frame_err and timeout_err are one-clk
//   event strobes, mutually exclusive with each other and with command_rx_ready.
//   dbg_bit_state / dbg_frame_state expose the two FSM state registers.
// Modports
//   master : the receiver (drives everything)
//   slave  : the consumer / checker
interface cmd_frame_rx_if;
  logic        command_rx_ready;
  logic [7:0]  command_rx;
  logic [31:0] data_field_rx;
  logic        rx_err;
  logic        frame_err;
  logic        timeout_err;
  logic [1:0]  dbg_bit_state;
  logic [2:0]  dbg_frame_state;

  modport master (
    output command_rx_ready, command_rx, data_field_rx,
    output rx_err, frame_err, timeout_err,
    output dbg_bit_state, dbg_frame_state
  );

  modport slave (
    input command_rx_ready, command_rx, data_field_rx,
    input rx_err, frame_err, timeout_err,
    input dbg_bit_state, dbg_frame_state
  );
endinterface

// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx
//   Receive-side command frame decoder for the RS422 command link. Oversamples uart_ro on
//   uart_tick, deserialises 8N1 bytes LSB first, and assembles 7-byte frames
//   (HEADER, cmd, d[31:24], d[23:16], d[15:8], d[7:0], chk). chk is the 8-bit wrapping sum of
//   cmd and the four data bytes. Good frames are presented with a one-clk ready strobe.
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset
//   uart_tick  one-clk sampling enable; all bit logic advances only on ticks
//   uart_ro    asynchronous serial line, idle high
//   rx_if      cmd_frame_rx_if.master: ready strobe, command/data, error strobes, FSM state
// Build option
//   CMD_RX_TIMEOUT_EN: enables the inter-byte timeout (TIMEOUT_TICKS uart_tick pulses while a
//   frame is partially received). Without it timeout_err is constant 0.
module cmd_frame_rx #(
  parameter int          OVERSAMPLE    = 16,
  parameter logic [7:0]  HEADER        = 8'hEB,
  parameter int          TIMEOUT_TICKS = 4096
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      uart_tick,
  input  logic      uart_ro,
  cmd_frame_rx_if.master rx_if
);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || TIMEOUT_TICKS < 1) begin : g_param_check
    $error("cmd_frame_rx: OVERSAMPLE must be even and >= 4, TIMEOUT_TICKS >= 1");
  end

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);

  localparam logic [1:0] B_IDLE  = 2'd0;
  localparam logic [1:0] B_START = 2'd1;
  localparam logic [1:0] B_DATA  = 2'd2;
  localparam logic [1:0] B_STOP  = 2'd3;

  localparam logic [2:0] F_HUNT = 3'd0;
  localparam logic [2:0] F_CMD  = 3'd1;
  localparam logic [2:0] F_D3   = 3'd2;
  localparam logic [2:0] F_D2   = 3'd3;
  localparam logic [2:0] F_D1   = 3'd4;
  localparam logic [2:0] F_D0   = 3'd5;
  localparam logic [2:0] F_CHK  = 3'd6;

  logic          sync1_q, sync2_q;
  logic [1:0]    bit_state_q, bit_state_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid, stop_err;

  logic [2:0]    frame_state_q, frame_state_d;
  logic [7:0]    cmd_buf_q, cmd_buf_d;
  logic [31:0]   data_buf_q, data_buf_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    command_rx_q, command_rx_d;
  logic [31:0]   data_field_rx_q, data_field_rx_d;
  logic          ready_q, ready_d;
  logic          rx_err_q, rx_err_d;
  logic          frame_err_q, frame_err_d;
  logic          timeout_hit;

  // Bit FSM. byte_valid/stop_err are combinational on the stop-sample clk so the frame FSM
  // registers its result on that same edge: ready appears 1 clk after the stop sample.
  always_comb begin
    bit_state_d = bit_state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_valid  = 1'b0;
    stop_err    = 1'b0;
    if (uart_tick) begin
      case (bit_state_q)
        B_IDLE: begin
          if (!sync2_q) begin
            bit_state_d = B_START;
            tick_cnt_d  = '0;
          end
        end
        B_START: begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d  = '0;
            bit_cnt_d   = '0;
            // A line that is high again at mid start bit was a glitch.
            bit_state_d = sync2_q ? B_IDLE : B_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        B_DATA: begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            shift_d    = {sync2_q, shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) bit_state_d = B_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: begin  // B_STOP
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d  = '0;
            bit_state_d = B_IDLE;
            if (sync2_q) byte_valid = 1'b1;
            else         stop_err   = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef CMD_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_err_q;

  // A byte completing in the timeout clk clears the counter and suppresses the timeout.
  always_comb begin
    to_cnt_d    = to_cnt_q;
    timeout_hit = 1'b0;
    if (byte_valid || frame_state_q == F_HUNT) begin
      to_cnt_d = '0;
    end else if (uart_tick) begin
      if (to_cnt_q == TO_LAST) begin
        timeout_hit = 1'b1;
        to_cnt_d    = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_hit && !stop_err;
    end
  end

  assign rx_if.timeout_err = timeout_err_q;
`else
  assign timeout_hit       = 1'b0;
  assign rx_if.timeout_err = 1'b0;
`endif

  // Frame FSM, advancing on byte_valid; stop errors and timeouts drop the partial frame.
  always_comb begin
    frame_state_d   = frame_state_q;
    cmd_buf_d       = cmd_buf_q;
    data_buf_d      = data_buf_q;
    sum_d           = sum_q;
    command_rx_d    = command_rx_q;
    data_field_rx_d = data_field_rx_q;
    ready_d         = 1'b0;
    rx_err_d        = 1'b0;
    frame_err_d     = 1'b0;
    if (stop_err) begin
      frame_err_d   = 1'b1;
      frame_state_d = F_HUNT;
    end else if (byte_valid) begin
      case (frame_state_q)
        F_HUNT: if (shift_q == HEADER) frame_state_d = F_CMD;
        F_CMD: begin
          cmd_buf_d     = shift_q;
          sum_d         = shift_q;
          frame_state_d = F_D3;
        end
        F_D3: begin
          data_buf_d[31:24] = shift_q;
          sum_d             = sum_q + shift_q;
          frame_state_d     = F_D2;
        end
        F_D2: begin
          data_buf_d[23:16] = shift_q;
          sum_d             = sum_q + shift_q;
          frame_state_d     = F_D1;
        end
        F_D1: begin
          data_buf_d[15:8] = shift_q;
          sum_d            = sum_q + shift_q;
          frame_state_d    = F_D0;
        end
        F_D0: begin
          data_buf_d[7:0] = shift_q;
          sum_d           = sum_q + shift_q;
          frame_state_d   = F_CHK;
        end
        F_CHK: begin
          if (shift_q == sum_q) begin
            command_rx_d    = cmd_buf_q;
            data_field_rx_d = data_buf_q;
            ready_d         = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
          frame_state_d = F_HUNT;
        end
        default: frame_state_d = F_HUNT;
      endcase
    end else if (timeout_hit) begin
      frame_state_d = F_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      bit_state_q     <= B_IDLE;
      tick_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      frame_state_q   <= F_HUNT;
      cmd_buf_q       <= '0;
      data_buf_q      <= '0;
      sum_q           <= '0;
      command_rx_q    <= '0;
      data_field_rx_q <= '0;
      ready_q         <= 1'b0;
      rx_err_q        <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      sync1_q         <= uart_ro;
      sync2_q         <= sync1_q;
      bit_state_q     <= bit_state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      frame_state_q   <= frame_state_d;
      cmd_buf_q       <= cmd_buf_d;
      data_buf_q      <= data_buf_d;
      sum_q           <= sum_d;
      command_rx_q    <= command_rx_d;
      data_field_rx_q <= data_field_rx_d;
      ready_q         <= ready_d;
      rx_err_q        <= rx_err_d;
      frame_err_q     <= frame_err_d;
    end
  end

  assign rx_if.command_rx_ready = ready_q;
  assign rx_if.command_rx       = command_rx_q;
  assign rx_if.data_field_rx    = data_field_rx_q;
  assign rx_if.rx_err           = rx_err_q;
  assign rx_if.frame_err        = frame_err_q;
  assign rx_if.dbg_bit_state    = bit_state_q;
  assign rx_if.dbg_frame_state  = frame_state_q;

endmodule
